// File: rtl/mem_pipe_reg_hs.sv
// EX->MEM pipeline register with valid/ready handshake, flush and a
// one-entry skid buffer so in_ready_o comes straight from a flop.
module mem_pipe_reg_hs #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              reg_wr_i,
  input  logic              mem_to_reg_i,
  input  logic              mem_wr_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [DATA_W-1:0] res_alu_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              reg_wr_o,
  output logic              mem_to_reg_o,
  output logic              mem_wr_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [DATA_W-1:0] res_alu_o,
  output logic [DATA_W-1:0] st_data_o
);

  localparam int E_W = 3 + RD_W + 2 * DATA_W;

  // Encoding is {main_v, skid_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [E_W-1:0] main_q, skid_q, in_ent;
  logic           accept, consume;
  logic           load_main, load_skid, move_skid;
  logic           head_rw, head_m2r, head_mw;

  assign in_ent = {reg_wr_i, mem_to_reg_i, mem_wr_i,
                   rd_i, res_alu_i, st_data_i};

  assign accept  = in_valid_i & in_ready_o & ~flush_i;
  assign consume = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept & ~consume)      state_d = FULL;
          else if (~accept & consume) state_d = EMPTY;
        end
        FULL: if (consume) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid_o = state_q[1];
    in_ready_o  = ~state_q[0];
    load_main   = accept & ((state_q == EMPTY) | consume);
    load_skid   = accept & ~consume & (state_q == ONE);
    move_skid   = ~flush_i & consume & (state_q == FULL);
  end

  // Payload flops are never cleared by flush; only valid state is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)      main_q <= in_ent;
      else if (move_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_ent;
    end
  end

  assign {head_rw, head_m2r, head_mw,
          rd_o, res_alu_o, st_data_o} = main_q;

  assign reg_wr_o     = head_rw  & out_valid_o;
  assign mem_to_reg_o = head_m2r & out_valid_o;
  assign mem_wr_o     = head_mw  & out_valid_o;

endmodule

// File: tb/tb_mem_pipe_reg_hs.sv
// Bench for mem_pipe_reg_hs: queue model, directed cases, random traffic.
// A second instance covers the wide-parameter build.
module tb_mem_pipe_reg_hs;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        mw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] st;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic        rw_i, m2r_i, mw_i, rw_o, m2r_o, mw_o;
  logic [4:0]  rd_i, rd_o;
  logic [31:0] res_i, res_o, st_i, st_o;

  logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic        w_rw_o, w_m2r_o, w_mw_o;
  logic [5:0]  w_rd_i, w_rd_o;
  logic [63:0] w_res_i, w_res_o, w_st_i, w_st_o;

  int vectors = 0;
  int miscompares = 0;

  ent_t q[$];
  ent_t cur;
  bit   m_acc, m_con;

  always #5 clk = ~clk;

  mem_pipe_reg_hs dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .reg_wr_i(rw_i), .mem_to_reg_i(m2r_i), .mem_wr_i(mw_i),
    .rd_i(rd_i), .res_alu_i(res_i), .st_data_i(st_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .reg_wr_o(rw_o), .mem_to_reg_o(m2r_o), .mem_wr_o(mw_o),
    .rd_o(rd_o), .res_alu_o(res_o), .st_data_o(st_o)
  );

  mem_pipe_reg_hs #(.DATA_W(64), .RD_W(6)) dut_w (
    .clk(clk), .reset(reset), .flush_i(w_flush),
    .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .reg_wr_i(1'b1), .mem_to_reg_i(1'b0), .mem_wr_i(1'b1),
    .rd_i(w_rd_i), .res_alu_i(w_res_i), .st_data_i(w_st_i),
    .out_valid_o(w_out_valid), .out_ready_i(w_out_ready),
    .reg_wr_o(w_rw_o), .mem_to_reg_o(w_m2r_o), .mem_wr_o(w_mw_o),
    .rd_o(w_rd_o), .res_alu_o(w_res_o), .st_data_o(w_st_o)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  assign cur = '{rw_i, m2r_i, mw_i, rd_i, res_i, st_i};

  // Reference: a FIFO of depth two, cleared by reset or flush
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_con = (q.size() > 0) && out_ready;
      if (m_con) void'(q.pop_front());
      if (m_acc) q.push_back(cur);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("reg_wr", rw_o, q[0].rw);
      chk("mem_to_reg", m2r_o, q[0].m2r);
      chk("mem_wr", mw_o, q[0].mw);
      chk("rd", rd_o, q[0].rd);
      chk("res_alu", res_o, q[0].res);
      chk("st_data", st_o, q[0].st);
    end else begin
      chk("reg_wr_gated", rw_o, 0);
      chk("m2r_gated", m2r_o, 0);
      chk("mem_wr_gated", mw_o, 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] st,
                       input logic rw, input logic m2r, input logic mw);
    in_valid = v;
    rd_i = rd;
    res_i = res;
    st_i = st;
    rw_i = rw;
    m2r_i = m2r;
    mw_i = mw;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 32'h99, 32'h77, 1'b1, 1'b1, 1'b1);
    w_flush = 1'b0;
    w_in_valid = 1'b0;
    w_out_ready = 1'b0;
    w_rd_i = '0;
    w_res_i = '0;
    w_st_i = '0;

    // Reset with valid input offered
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_reg_wr", rw_o, 0);
    chk("rst_mem_wr", mw_o, 0);
    chk("rst_m2r", m2r_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_st", st_o, 0);
    reset = 1'b0;
    cyc();
    chk("first_valid", out_valid, 1);
    chk("first_rd", rd_o, 9);
    chk("first_res", res_o, 32'h99);
    chk("first_reg_wr", rw_o, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("drain_valid", out_valid, 0);

    // Streaming one per cycle
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 32'(i * 16), 32'(i), 1'b1, 1'b0, 1'b0);
      cyc();
      chk("stream_rd", rd_o, 64'(i));
      chk("stream_res", res_o, 64'(i * 16));
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("stream_end", out_valid, 0);

    // Backpressure into skid
    out_ready = 1'b0;
    drive(1'b1, 5'd10, 32'hA, 32'hA0, 1'b1, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd11, 32'hB, 32'hB0, 1'b0, 1'b0, 1'b1);
    cyc();
    chk("bp_ready_low", in_ready, 0);
    chk("bp_head_A", rd_o, 10);
    in_valid = 1'b0;
    cyc();
    chk("bp_hold_A", res_o, 32'hA);
    out_ready = 1'b1;
    cyc();
    chk("bp_head_B", rd_o, 11);
    chk("bp_B_mem_wr", mw_o, 1);
    chk("bp_ready_back", in_ready, 1);
    cyc();
    chk("bp_empty", out_valid, 0);

    // Flush while full, accept offered
    out_ready = 1'b0;
    drive(1'b1, 5'd12, 32'hC, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc();
    cyc();
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 5'd31, 32'hF, 32'h0, 1'b1, 1'b0, 1'b1);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_reg_wr", rw_o, 0);
    chk("fl_mem_wr", mw_o, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    cyc();
    chk("fl_no_ghost", out_valid, 0);

    // Wide build
    w_in_valid = 1'b1;
    w_rd_i = 6'h3F;
    w_res_i = 64'hDEAD_BEEF_0123_4567;
    w_st_i = 64'hFEDC_BA98_7654_3210;
    cyc();
    w_in_valid = 1'b0;
    chk("w_valid", w_out_valid, 1);
    chk("w_rd", w_rd_o, 6'h3F);
    chk("w_res", w_res_o, 64'hDEAD_BEEF_0123_4567);
    chk("w_st", w_st_o, 64'hFEDC_BA98_7654_3210);
    chk("w_reg_wr", w_rw_o, 1);
    chk("w_m2r", w_m2r_o, 0);
    w_out_ready = 1'b1;
    cyc();
    chk("w_empty", w_out_valid, 0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom), 5'($urandom), $urandom, $urandom,
            1'($urandom), 1'($urandom), 1'($urandom));
      out_ready = 1'($urandom);
      flush = ($urandom_range(31) == 0);
      if (i == 5000) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
